// File: rtl/adder.sv
// N-bit ripple-carry adder with carry-in/out; {Cout,S} = A + B + Cin registered, 1-cycle latency.
// Accepts one operation every cycle (no backpressure); out_valid tags each captured result.
module adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         out_valid
);

  logic [N-1:0] w_sum;
  logic         w_cout;

  logic [N-1:0] r_s;
  logic         r_cout;
  logic         r_vld;

  // Each stage owns its carry signals so the chain is a plain net-to-net ripple.
  for (genvar i = 0; i < N; i++) begin : g_fa
    logic w_ci;
    logic w_co;

    if (i == 0) begin : g_first
      assign w_ci = Cin;
    end else begin : g_next
      assign w_ci = g_fa[i-1].w_co;
    end

    assign w_sum[i] = A[i] ^ B[i] ^ w_ci;
    assign w_co     = (A[i] & B[i]) | (A[i] & w_ci) | (B[i] & w_ci);
  end

  assign w_cout = g_fa[N-1].w_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_s    <= w_sum;
        r_cout <= w_cout;
      end
    end
  end

  assign S         = r_s;
  assign Cout      = r_cout;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_adder.sv
// Drives eight adder instances (N = 1..64) in parallel and checks them against an arithmetic model.
module tb_adder;

  localparam int NI = 8;
  localparam int WID [NI] = '{1, 2, 4, 6, 8, 16, 32, 64};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a    [NI];
  logic [63:0] b    [NI];
  logic        cin  [NI];
  logic        iv   [NI];
  logic [63:0] s_o  [NI];
  logic        cout [NI];
  logic        ov   [NI];

  logic [64:0] e_res [NI];
  logic        e_ov  [NI];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [WID[g]-1:0] w_s;
    logic              w_co;
    logic              w_ov;

    adder #(.N(WID[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .A         (a[g][WID[g]-1:0]),
      .B         (b[g][WID[g]-1:0]),
      .Cin       (cin[g]),
      .S         (w_s),
      .Cout      (w_co),
      .out_valid (w_ov)
    );

    assign s_o[g]  = 64'(w_s);
    assign cout[g] = w_co;
    assign ov[g]   = w_ov;
  end

  function automatic logic [63:0] mask(int n);
    logic [63:0] m;
    m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return m;
  endfunction

  // Reference: plain (N+1)-bit unsigned addition of zero-extended operands.
  function automatic logic [64:0] ref_sum(int n, logic [63:0] x, logic [63:0] y, logic c);
    logic [64:0] r;
    r = 65'(x & mask(n)) + 65'(y & mask(n)) + 65'(c);
    return r;
  endfunction

  function automatic logic [64:0] obs(int i);
    logic [64:0] r;
    r = 65'(s_o[i]) | (65'(cout[i]) << WID[i]);
    return r;
  endfunction

  task automatic chk(string tag, logic [64:0] got, logic [64:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_n%0d_res", tag, WID[i]), obs(i), e_res[i]);
      chk($sformatf("%s_n%0d_vld", tag, WID[i]), 65'(ov[i]), 65'(e_ov[i]));
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) begin
      iv[i]  = 1'b0;
      a[i]   = '0;
      b[i]   = '0;
      cin[i] = 1'b0;
    end
  endtask

  task automatic set_op(int i, logic [63:0] x, logic [63:0] y, logic c);
    iv[i]  = 1'b1;
    a[i]   = x & mask(WID[i]);
    b[i]   = y & mask(WID[i]);
    cin[i] = c;
  endtask

  task automatic model_zero();
    for (int i = 0; i < NI; i++) begin
      e_res[i] = '0;
      e_ov[i]  = 1'b0;
    end
  endtask

  // Advance one clock: predict from the inputs presented, then sample after the edge.
  task automatic step(string tag);
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        e_res[i] = '0;
        e_ov[i]  = 1'b0;
      end else if (iv[i]) begin
        e_res[i] = ref_sum(WID[i], a[i], b[i], cin[i]);
        e_ov[i]  = 1'b1;
      end else begin
        e_ov[i]  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges must clear outputs with no clock.
  task automatic mid_reset(string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_zero();
    check_all(tag);
  endtask

  logic [2:0]  tt;
  logic [63:0] st_a [4];
  logic [63:0] st_b [4];
  logic        st_c [4];
  logic [64:0] st_e [4];

  initial begin
    clear_inputs();
    model_zero();
    #1;
    check_all("reset_state");

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle0");
    step("idle1");

    // Result in flight is discarded by a mid-cycle reset.
    set_op(4, 64'd3, 64'd4, 1'b0);
    step("pre_rst");
    chk("pre_rst_const", obs(4), 65'd7);
    set_op(4, 64'd100, 64'd50, 1'b1);
    mid_reset("async_rst");
    step("rst_hold");
    rst_n = 1'b1;
    clear_inputs();
    step("rst_release");

    // N = 1 full truth table
    for (int v = 0; v < 8; v++) begin
      clear_inputs();
      tt = 3'(v);
      set_op(0, 64'(tt[2]), 64'(tt[1]), tt[0]);
      step($sformatf("tt%0d", v));
      if (v == 2) chk("tt_0p1p0", obs(0), 65'b01);
      if (v == 7) chk("tt_1p1p1", obs(0), 65'b11);
    end

    // Small widths and carry propagation, all in one cycle
    clear_inputs();
    set_op(1, 64'd2, 64'd1, 1'b1);
    set_op(2, 64'b1010, 64'b0101, 1'b0);
    set_op(3, 64'd40, 64'd15, 1'b1);
    set_op(4, 64'd120, 64'd130, 1'b0);
    set_op(5, 64'h0FFF, 64'h0001, 1'b1);
    set_op(6, 64'hFFFF_FFFF, 64'h1, 1'b0);
    set_op(7, '1, 64'h1, 1'b1);
    step("widths");
    chk("n2_const",  obs(1), 65'b100);
    chk("n4_const",  obs(2), 65'b01111);
    chk("n6_const",  obs(3), 65'd56);
    chk("n8_const",  obs(4), 65'd250);
    chk("n16_const", obs(5), 65'h0_1001);
    chk("n32_const", obs(6), 65'h1_0000_0000);
    chk("n64_const", obs(7), {1'b1, 64'h1});

    // Streaming on N = 8
    st_a = '{64'd1, 64'd255, 64'd255, 64'd0};
    st_b = '{64'd1, 64'd1, 64'd255, 64'd0};
    st_c = '{1'b0, 1'b0, 1'b1, 1'b0};
    st_e = '{65'h002, 65'h100, 65'h1FF, 65'h000};
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      set_op(4, st_a[k], st_b[k], st_c[k]);
      step($sformatf("stream%0d", k));
      chk($sformatf("stream%0d_const", k), obs(4), st_e[k]);
      chk($sformatf("stream%0d_vld", k), 65'(ov[4]), 65'd1);
    end
    clear_inputs();
    step("stream_drop");
    chk("stream_drop_vld", 65'(ov[4]), 65'd0);
    chk("stream_drop_hold", obs(4), 65'd0);

    // Random operands with valid gaps, extreme values and occasional resets
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NI; i++) begin
        iv[i]  = ($urandom_range(0, 3) != 0);
        a[i]   = (($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom}) & mask(WID[i]);
        b[i]   = (($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom}) & mask(WID[i]);
        cin[i] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 499) == 0) begin
        mid_reset("rnd_rst");
        step("rnd_rst_hold");
        rst_n = 1'b1;
      end else begin
        step("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder.md
# adder

Parameterised N-bit binary adder with carry-in and carry-out. It registers the sum on the clock edge. It is the shared arithmetic primitive for datapaths of width 1 to 64 bits. Every instance computes the unsigned sum A + B + Cin and presents it one cycle later, tagged by a valid flag.

## Interface
- N, default 8: operand and sum width in bits. Legal range 1..64; the instances in use are 1, 2, 4, 6, 8, 16, 32 and 64.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  A, B and Cin are valid this cycle.
- A  input  N  operand A, unsigned.
- B  input  N  operand B, unsigned.
- Cin  input  1  carry into bit 0.
- S  output  N  registered sum, bits [N-1:0] of A + B + Cin.
- Cout  output  1  registered carry out of bit N-1, i.e. bit N of A + B + Cin.
- out_valid  output  1  S and Cout hold the result of an accepted input.

## Operation
- Arithmetic: the block forms an (N+1)-bit result {Cout, S} = A + B + Cin, with operands zero-extended and no signed interpretation.
- Wrap-around: the sum is taken modulo 2^N into S; the overflow bit goes to Cout.
- Maximum input: A = B = 2^N-1 and Cin = 1 gives S = 2^N-1 and Cout = 1.
- Core structure: an N-stage ripple-carry chain of full adders.
  - Stage i: s_i = a_i ^ b_i ^ c_i and c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = Cin; Cout = c_N.
  - The chain is built with a generate loop, so N = 1 degenerates to a single full adder.
- Capture: when in_valid = 1 at a rising clk, S and Cout load the chain result and out_valid goes to 1.
- Hold: when in_valid = 0 at a rising clk, S and Cout keep their previous values and out_valid goes to 0.
- No back-pressure: the block accepts one operation per cycle unconditionally.
- Undefined inputs: X or Z on A, B or Cin while in_valid = 1 may propagate to the outputs. No X-scrubbing is required.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge k appear on S, Cout and out_valid right after edge k.
- Throughput: one result per cycle; back-to-back valid inputs give back-to-back valid outputs.
- Reset: rst_n = 0 forces S = 0, Cout = 0 and out_valid = 0 immediately, without waiting for a clock edge.
- Reset hold: these values are held while rst_n is low.
- Reset release: the first capture happens on the first rising clk after rst_n is high.
- Reset mid-operation: a result in flight is discarded, and out_valid does not assert for it.
- Combinational path: A/B/Cin to the S/Cout registers is a single ripple chain of N full-adder stages. The implementation must close timing at N = 64 at the project clock. No internal pipelining is permitted, because it would change the latency.

## Test plan
- Reset: drive rst_n = 0 asynchronously mid-cycle -> S = 0, Cout = 0 and out_valid = 0 with no clock edge. Release, then hold in_valid = 0 for 2 cycles -> out_valid stays 0.
- N = 1 full truth table: all 8 combinations of A, B and Cin.
  - 0+1+0 -> S = 1, Cout = 0.
  - 1+1+1 -> S = 1, Cout = 1.
  - Each result appears 1 cycle after its input.
- Small widths:
  - N = 2: 2+1+1 -> S = 00, Cout = 1.
  - N = 4: 1010+0101+0 -> S = 1111, Cout = 0.
  - N = 6: 40+15+1 -> S = 111000 (56), Cout = 0.
  - N = 8: 120+130+0 -> S = 250, Cout = 0.
- Carry propagation:
  - N = 16: 0FFF+0001+1 -> S = 1001, Cout = 0.
  - N = 32: FFFFFFFF+00000001+0 -> S = 00000000, Cout = 1.
  - N = 64: all ones + 1 + 1 -> S = 0000000000000001, Cout = 1.
- Streaming: N = 8 with in_valid high for 4 consecutive cycles, inputs (1,1,0), (255,1,0), (255,255,1), (0,0,0).
  - Expected results on consecutive cycles: (2,0), (0,1), (255,1), (0,0).
  - Then drop in_valid -> out_valid = 0 and S/Cout hold 0/0.
- Random: 10k random A, B and Cin for each N in {1, 2, 4, 6, 8, 16, 32, 64}, with random in_valid gaps. Check {Cout, S} == A + B + Cin against an (N+1)-bit reference model. Assert reset at random points and check the rules in Timing.
